// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: FSM state codes and counter sizing shared by the serializer files.
// Revision: 1.0
`default_nettype none

package piso_serializer_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serializer_bit_counter.sv
// serializer_bit_counter: bit-position counter with clear/increment and terminal-count flag.
// Revision: 1.0
`default_nettype none

module serializer_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // clear wins over inc so a reload on the last bit restarts at position 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == LAST_CNT);

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, one bit per clock serial-out with first/last strobes.
// Revision: 1.0
`default_nettype none

module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_data,
  input  logic             p_valid,
  output logic             p_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_first,
  output logic             s_last,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             in_shift;
  logic             xfer;
  logic             head;

  assign in_shift = (state == ST_SHIFT);

  // ready depends only on registered state and the reset pin, never on p_valid
  assign p_ready = rst && ((state == ST_IDLE) || (in_shift && tc));
  assign xfer    = p_valid && p_ready;

  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign head         = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

  serializer_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (xfer || (in_shift && tc)),
    .inc   (in_shift && !tc),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      sreg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            sreg  <= p_data;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tc) begin
            if (xfer) begin
              sreg <= p_data;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            sreg <= sreg_shifted;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = in_shift;
  assign s_valid = in_shift;
  assign s_out   = in_shift ? head : IDLE_LEVEL;
  assign s_first = in_shift && (cnt == '0);
  assign s_last  = in_shift && tc;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: MSB-first/idle-0 and LSB-first/idle-1 instances checked against a word-queue model.
// Revision: 1.0
`default_nettype none

module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] p_data = '0;
  logic       p_valid = 1'b0;

  logic p_ready0, s_out0, s_valid0, s_first0, s_last0, busy0;
  logic p_ready1, s_out1, s_valid1, s_first1, s_last1, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready0),
    .s_out(s_out0), .s_valid(s_valid0), .s_first(s_first0), .s_last(s_last0), .busy(busy0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready1),
    .s_out(s_out1), .s_valid(s_valid1), .s_first(s_first1), .s_last(s_last1), .busy(busy1)
  );

  // Model: one entry per payload bit still to appear on the line (head = current cycle)
  typedef struct {
    logic [7:0] data;
    int         pos;
  } bit_t;
  bit_t q[$];

  function automatic logic [5:0] exp_vec(input bit lsb, input bit idle);
    logic rdy;
    logic b;
    rdy = rst && (q.size() <= 1);
    if (q.size() == 0) return {1'b0, 1'b0, idle, 1'b0, 1'b0, rdy};
    b = lsb ? q[0].data[q[0].pos] : q[0].data[7 - q[0].pos];
    return {1'b1, 1'b1, b, q[0].pos == 0, q[0].pos == 7, rdy};
  endfunction

  function automatic logic [5:0] obs0();
    return {busy0, s_valid0, s_out0, s_first0, s_last0, p_ready0};
  endfunction

  function automatic logic [5:0] obs1();
    return {busy1, s_valid1, s_out1, s_first1, s_last1, p_ready1};
  endfunction

  // Advance one clock: the model consumes a bit and captures on a handshake
  task automatic drive(input logic v, input logic [7:0] d);
    logic       xfer;
    logic [7:0] cap;
    xfer = p_valid && rst && (q.size() <= 1);
    cap  = p_data;
    @(posedge clk);
    if (rst) begin
      if (q.size() > 0) void'(q.pop_front());
      if (xfer) for (int i = 0; i < 8; i++) q.push_back('{cap, i});
    end
    @(negedge clk);
    p_valid = v;
    p_data  = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; p_valid = 1'b1; p_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hFF);
      checks++; if (obs0() !== exp_vec(0, 0)) begin errors++; $display("FAIL reset_hold0 c%0d got=%b want=%b", i, obs0(), exp_vec(0, 0)); end
      checks++; if (obs1() !== exp_vec(1, 1)) begin errors++; $display("FAIL reset_hold1 c%0d got=%b want=%b", i, obs1(), exp_vec(1, 1)); end
      checks++; if ({p_ready0, s_valid0, s_out0} !== 3'b000) begin errors++; $display("FAIL reset_const c%0d got=%b want=000", i, {p_ready0, s_valid0, s_out0}); end
    end
    p_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (p_ready0 !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b want=1", p_ready0); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'h00);
      checks++; if (obs0() !== exp_vec(0, 0)) begin errors++; $display("FAIL reset_idle0 c%0d got=%b want=%b", i, obs0(), exp_vec(0, 0)); end
      checks++; if (s_valid0 !== 1'b0 || s_valid1 !== 1'b0) begin errors++; $display("FAIL reset_nocapture got=%b%b want=00", s_valid0, s_valid1); end
    end
  endtask

  task automatic test_single_word();
    logic [7:0] pat;
    pat = 8'hA5;
    drive(1'b1, pat);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'($urandom));
      checks++; if (obs0() !== exp_vec(0, 0)) begin errors++; $display("FAIL single0 b%0d got=%b want=%b", i, obs0(), exp_vec(0, 0)); end
      checks++; if (obs1() !== exp_vec(1, 1)) begin errors++; $display("FAIL single1 b%0d got=%b want=%b", i, obs1(), exp_vec(1, 1)); end
      checks++;
      if ({s_valid0, s_out0, s_first0, s_last0} !== {1'b1, pat[7-i], i == 0, i == 7}) begin
        errors++; $display("FAIL single_a5 b%0d got=%b want=%b", i, {s_valid0, s_out0, s_first0, s_last0}, {1'b1, pat[7-i], i == 0, i == 7});
      end
    end
    drive(1'b0, 8'h00);
    checks++; if ({s_valid0, s_out0} !== 2'b00) begin errors++; $display("FAIL single_after got=%b want=00", {s_valid0, s_out0}); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat;
    pat = 16'hA53C;
    drive(1'b1, 8'hA5);
    for (int c = 1; c <= 16; c++) begin
      drive(c <= 8, 8'h3C);
      checks++; if (obs0() !== exp_vec(0, 0)) begin errors++; $display("FAIL b2b0 c%0d got=%b want=%b", c, obs0(), exp_vec(0, 0)); end
      checks++; if (obs1() !== exp_vec(1, 1)) begin errors++; $display("FAIL b2b1 c%0d got=%b want=%b", c, obs1(), exp_vec(1, 1)); end
      checks++;
      if ({s_valid0, s_out0, s_first0, p_ready0} !== {1'b1, pat[16-c], c == 1 || c == 9, c == 8 || c == 16}) begin
        errors++; $display("FAIL b2b_const c%0d got=%b want=%b", c, {s_valid0, s_out0, s_first0, p_ready0},
                            {1'b1, pat[16-c], c == 1 || c == 9, c == 8 || c == 16});
      end
    end
    drive(1'b0, 8'h00);
    checks++; if (s_valid0 !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b want=0", s_valid0); end
  endtask

  task automatic test_lsb_idle();
    logic [7:0] pat;
    pat = 8'h01;
    checks++; if (s_out1 !== 1'b1) begin errors++; $display("FAIL lsb_idle_before got=%b want=1", s_out1); end
    drive(1'b1, pat);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00);
      checks++; if (obs1() !== exp_vec(1, 1)) begin errors++; $display("FAIL lsb1 b%0d got=%b want=%b", i, obs1(), exp_vec(1, 1)); end
      checks++; if (s_out1 !== pat[i]) begin errors++; $display("FAIL lsb_bit b%0d got=%b want=%b", i, s_out1, pat[i]); end
    end
    drive(1'b0, 8'h00);
    checks++; if ({s_valid1, s_out1} !== 2'b01) begin errors++; $display("FAIL lsb_idle_after got=%b want=01", {s_valid1, s_out1}); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] pat;
    drive(1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00);
      checks++; if (obs0() !== exp_vec(0, 0)) begin errors++; $display("FAIL midrst_pre b%0d got=%b want=%b", i, obs0(), exp_vec(0, 0)); end
    end
    #2;
    rst = 1'b0;
    q.delete();
    #1;
    checks++;
    if ({s_valid0, s_out0, s_valid1, s_out1, p_ready0} !== 5'b00010) begin
      errors++; $display("FAIL midrst_async got=%b want=00010", {s_valid0, s_out0, s_valid1, s_out1, p_ready0});
    end
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    rst = 1'b1;
    #1;
    pat = 8'h80;
    drive(1'b1, pat);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00);
      checks++; if (obs0() !== exp_vec(0, 0)) begin errors++; $display("FAIL midrst_post0 b%0d got=%b want=%b", i, obs0(), exp_vec(0, 0)); end
      checks++;
      if ({s_out0, s_out1} !== {pat[7-i], pat[i]}) begin
        errors++; $display("FAIL midrst_bits b%0d got=%b want=%b", i, {s_out0, s_out1}, {pat[7-i], pat[i]});
      end
    end
    drive(1'b0, 8'h00);
    checks++; if (s_valid0 !== 1'b0) begin errors++; $display("FAIL midrst_end got=%b want=0", s_valid0); end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, 8'($urandom));
      checks++; if (obs0() !== exp_vec(0, 0)) begin errors++; $display("FAIL stall0 c%0d got=%b want=%b", c, obs0(), exp_vec(0, 0)); end
      checks++; if (obs1() !== exp_vec(1, 1)) begin errors++; $display("FAIL stall1 c%0d got=%b want=%b", c, obs1(), exp_vec(1, 1)); end
    end
    for (int c = 0; c < 10; c++) drive(1'b0, 8'($urandom));
    checks++; if (obs0() !== exp_vec(0, 0)) begin errors++; $display("FAIL stall_drain got=%b want=%b", obs0(), exp_vec(0, 0)); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom % 4) != 0, 8'($urandom));
      checks++; if (obs0() !== exp_vec(0, 0)) begin errors++; $display("FAIL rand0 c%0d got=%b want=%b", c, obs0(), exp_vec(0, 0)); end
      checks++; if (obs1() !== exp_vec(1, 1)) begin errors++; $display("FAIL rand1 c%0d got=%b want=%b", c, obs1(), exp_vec(1, 1)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_idle();
    test_reset_mid_word();
    test_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
